// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard controller: forwarding selects, FSM states
// and the decode encoding that marks a load.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  // The younger producer (MEM) holds the newer value, so it wins over WB.
  function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FWD_MEM;
    end
    if (wb_hit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Register-tag comparator: a producer matches a consumer source only if it
// writes the register file and its destination is not x0.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic                  i_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_rs,
  output logic                  o_match
);

  assign o_match = i_reg_write && (i_rd != '0) && (i_rd == i_rs);

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage RV32I pipeline: forwarding selects,
// load-use/branch/memory-wait stall and flush. Operand forwarding is built only
// when HAZARD_FORWARD_EN is defined; otherwise RAW hazards stall instead.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_result_src,
  input  logic                  ex_pc_src,
  input  logic                  mem_access,
  input  logic                  mem_ready,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w
);

  localparam int NOPS = 2;

  hz_state_t r_state;
  hz_state_t w_state_next;

  logic [ADDR_WIDTH-1:0] r_ex_rd;
  logic                  r_ex_reg_write;
  logic                  r_ex_is_load;
  logic [ADDR_WIDTH-1:0] r_mem_rd;
  logic                  r_mem_reg_write;

  logic [ADDR_WIDTH-1:0] w_id_rs [NOPS];
  logic [NOPS-1:0]       w_lu_hit;
  logic [NOPS-1:0]       w_raw_hit;
  logic                  w_hazard;
  logic                  w_mem_stall;
  logic                  w_id_is_load;

  assign w_id_rs[0]   = id_rs1;
  assign w_id_rs[1]   = id_rs2;
  assign w_id_is_load = (id_result_src == RESULT_SRC_LOAD);

  generate
    for (genvar gi = 0; gi < NOPS; gi++) begin : g_id_src
      hazard_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_load_use (
        .i_rd        (r_ex_rd),
        .i_reg_write (r_ex_is_load),
        .i_rs        (w_id_rs[gi]),
        .o_match     (w_lu_hit[gi])
      );
`ifdef HAZARD_FORWARD_EN
      assign w_raw_hit[gi] = 1'b0;
`else
      // Without bypass paths any EX or MEM producer must reach WB first.
      logic w_ex_hit;
      logic w_mem_hit;
      hazard_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_raw_ex (
        .i_rd        (r_ex_rd),
        .i_reg_write (r_ex_reg_write),
        .i_rs        (w_id_rs[gi]),
        .o_match     (w_ex_hit)
      );
      hazard_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_raw_mem (
        .i_rd        (r_mem_rd),
        .i_reg_write (r_mem_reg_write),
        .i_rs        (w_id_rs[gi]),
        .o_match     (w_mem_hit)
      );
      assign w_raw_hit[gi] = w_ex_hit | w_mem_hit;
`endif
    end
  endgenerate

  assign w_hazard = (|w_lu_hit) | (|w_raw_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority: memory wait, then taken branch, then data hazard.
  always_comb begin
    w_state_next = r_state;
    w_mem_stall  = 1'b0;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_w      = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (mem_access && !mem_ready) begin
            w_mem_stall  = 1'b1;
            w_state_next = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            w_state_next = RUN;
          end else begin
            w_mem_stall = 1'b1;
          end
        end
        default: w_state_next = RUN;
      endcase
      if (w_mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (ex_pc_src) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (w_hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Shadow tags track the datapath registers: EX/MEM hold during a memory
  // wait while WB receives a bubble; flush_e turns EX into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rd         <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_is_load    <= 1'b0;
      r_mem_rd        <= '0;
      r_mem_reg_write <= 1'b0;
    end else if (!w_mem_stall) begin
      r_mem_rd        <= r_ex_rd;
      r_mem_reg_write <= r_ex_reg_write;
      if (flush_e) begin
        r_ex_rd        <= '0;
        r_ex_reg_write <= 1'b0;
        r_ex_is_load   <= 1'b0;
      end else begin
        r_ex_rd        <= id_rd;
        r_ex_reg_write <= id_reg_write;
        r_ex_is_load   <= w_id_is_load;
      end
    end
  end

`ifdef HAZARD_FORWARD_EN
  logic [ADDR_WIDTH-1:0] r_ex_rs1;
  logic [ADDR_WIDTH-1:0] r_ex_rs2;
  logic [ADDR_WIDTH-1:0] r_wb_rd;
  logic                  r_wb_reg_write;
  logic [ADDR_WIDTH-1:0] w_ex_rs [NOPS];
  fwd_sel_t              w_fwd   [NOPS];

  assign w_ex_rs[0] = r_ex_rs1;
  assign w_ex_rs[1] = r_ex_rs2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
    end else if (w_mem_stall) begin
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
    end else begin
      r_wb_rd        <= r_mem_rd;
      r_wb_reg_write <= r_mem_reg_write;
      r_ex_rs1       <= flush_e ? '0 : id_rs1;
      r_ex_rs2       <= flush_e ? '0 : id_rs2;
    end
  end

  generate
    for (genvar gi = 0; gi < NOPS; gi++) begin : g_fwd
      logic w_mem_hit;
      logic w_wb_hit;
      hazard_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_mem (
        .i_rd        (r_mem_rd),
        .i_reg_write (r_mem_reg_write),
        .i_rs        (w_ex_rs[gi]),
        .o_match     (w_mem_hit)
      );
      hazard_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_wb (
        .i_rd        (r_wb_rd),
        .i_reg_write (r_wb_reg_write),
        .i_rs        (w_ex_rs[gi]),
        .o_match     (w_wb_hit)
      );
      assign w_fwd[gi] = fwd_pick(w_mem_hit, w_wb_hit);
    end
  endgenerate

  assign fwd_a_sel = w_fwd[0];
  assign fwd_b_sel = w_fwd[1];
`else
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

endmodule
